// File: rtl/x_dac_pkg.sv
// x_dac_pkg: shared definitions for the thermometer DAC path.
//   BW(n)       : code width for an n-wide thermometer DAC ($clog2(n))
//   midscale(n) : midscale code (n/2), used as the idle/reset output code
//   code_t      : code type for the default 64-wide DAC
package x_dac_pkg;

   localparam int N_DEF = 64;

   function automatic int BW(input int n);
      return $clog2(n);
   endfunction

   function automatic int midscale(input int n);
      return n / 2;
   endfunction

   typedef logic [BW(N_DEF)-1:0] code_t;

endpackage

// File: rtl/x_sync_fifo.sv
// x_sync_fifo: single-clock FIFO, registered storage, combinational head read.
//   clk, rst       : clock, synchronous active-high reset (pointers only)
//   push, wdata    : write request/data, ignored while full
//   pop            : read request, ignored while empty
//   rdata          : head entry (valid while !empty)
//   full, empty    : occupancy flags
//   level          : current occupancy, 0..DEPTH
module x_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign level = wptr - rptr;
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + 1'b1;
         if (pop && !empty) rptr <= rptr + 1'b1;
      end
   end

endmodule

// File: rtl/x_dac_sample_sched.sv
// x_dac_sample_sched: buffers upstream DAC codes and releases one per
// programmable sample period to x_bin_to_therm.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_en                : scheduler enable (period counter runs while high)
//   i_div               : sample period minus one, in clocks
//   i_valid/i_data      : upstream code handshake, o_ready back-pressure
//   o_bin, o_strobe     : released code and its one-cycle "new code" pulse
//   o_underflow         : sticky, set when a release finds the FIFO empty
//   i_clr_underflow     : clears o_underflow (a coincident set wins)
//   o_level             : FIFO occupancy
module x_dac_sample_sched
   import x_dac_pkg::*;
#(
   parameter int N     = 64,
   parameter int DEPTH = 4,
   parameter int DIV_W = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic [DIV_W-1:0]         i_div,
   input  logic                     i_valid,
   input  logic [BW(N)-1:0]         i_data,
   output logic                     o_ready,
   output logic [BW(N)-1:0]         o_bin,
   output logic                     o_strobe,
   output logic                     o_underflow,
   input  logic                     i_clr_underflow,
   output logic [$clog2(DEPTH):0]   o_level
);

   localparam int CW = BW(N);
   localparam logic [CW-1:0] MID = CW'(midscale(N));

   logic [DIV_W-1:0] cnt;
   logic             tick;
   logic             push;
   logic             pop;
   logic             full;
   logic             empty;
   logic [CW-1:0]    head;

   // Ready depends only on registered occupancy (plus reset), never on pop,
   // so a full FIFO refuses a push even in a cycle that drains it.
   assign o_ready = !full && !i_rst;
   assign push    = i_valid && o_ready;

   // ">=" makes a lowered divider end the current period immediately.
   assign tick = i_en && (cnt >= i_div);
   assign pop  = tick && !empty;

   x_sync_fifo #(
      .WIDTH (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (i_clk),
      .rst   (i_rst),
      .push  (push),
      .wdata (i_data),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .level (o_level)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (!i_en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   // Emptiness is judged before this cycle's push: no bypass of a fresh code.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_bin       <= MID;
         o_strobe    <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_strobe <= pop;
         if (pop) o_bin <= head;
         if (tick && empty)        o_underflow <= 1'b1;
         else if (i_clr_underflow) o_underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_x_dac_sample_sched.sv
// Bench for x_dac_sample_sched: directed walk through the main scenarios
// followed by randomized traffic, all checked every cycle against a
// queue-based reference model.
module tb_x_dac_sample_sched;

   localparam int N     = 64;
   localparam int DEPTH = 4;
   localparam int DIV_W = 16;
   localparam int CW    = $clog2(N);

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_en;
   logic [DIV_W-1:0] i_div;
   logic             i_valid;
   logic [CW-1:0]    i_data;
   logic             o_ready;
   logic [CW-1:0]    o_bin;
   logic             o_strobe;
   logic             o_underflow;
   logic             i_clr_underflow;
   logic [$clog2(DEPTH):0] o_level;

   int n_vec = 0;
   int n_err = 0;

   // reference model state (post-edge view)
   int m_q[$];
   int m_cnt;
   int m_bin;
   bit m_strobe;
   bit m_uf;

   x_dac_sample_sched #(
      .N     (N),
      .DEPTH (DEPTH),
      .DIV_W (DIV_W)
   ) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_en            (i_en),
      .i_div           (i_div),
      .i_valid         (i_valid),
      .i_data          (i_data),
      .o_ready         (o_ready),
      .o_bin           (o_bin),
      .o_strobe        (o_strobe),
      .o_underflow     (o_underflow),
      .i_clr_underflow (i_clr_underflow),
      .o_level         (o_level)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock: evaluate the model on the inputs present at the
   // edge, then compare every output just after the edge.
   task automatic step();
      int  nbin;
      int  ncnt;
      bit  nstb;
      bit  nuf;
      bit  tick;
      bit  was_empty;
      bit  accept;
      if (i_rst) begin
         m_q.delete();
         nbin = N / 2;
         ncnt = 0;
         nstb = 1'b0;
         nuf  = 1'b0;
      end else begin
         accept    = i_valid && (m_q.size() < DEPTH);
         tick      = i_en && (m_cnt >= int'(i_div));
         was_empty = (m_q.size() == 0);
         nbin      = m_bin;
         nstb      = 1'b0;
         nuf       = m_uf;
         if (tick && !was_empty) begin
            nbin = m_q.pop_front();
            nstb = 1'b1;
         end
         if (tick && was_empty)     nuf = 1'b1;
         else if (i_clr_underflow)  nuf = 1'b0;
         if (accept) m_q.push_back(int'(i_data));
         ncnt = (!i_en || tick) ? 0 : m_cnt + 1;
      end
      @(posedge i_clk);
      #1;
      m_bin    = nbin;
      m_cnt    = ncnt;
      m_strobe = nstb;
      m_uf     = nuf;
      chk("bin",       int'(o_bin),       m_bin);
      chk("strobe",    int'(o_strobe),    int'(m_strobe));
      chk("underflow", int'(o_underflow), int'(m_uf));
      chk("level",     int'(o_level),     m_q.size());
      chk("ready",     int'(o_ready),     int'((m_q.size() < DEPTH) && !i_rst));
   endtask

   task automatic push_code(input int c);
      i_valid = 1'b1;
      i_data  = CW'(c);
      step();
      i_valid = 1'b0;
   endtask

   task automatic clear_uf();
      i_clr_underflow = 1'b1;
      step();
      i_clr_underflow = 1'b0;
   endtask

   initial begin
      i_rst = 1'b1; i_en = 1'b0; i_div = '0; i_valid = 1'b0;
      i_data = '0; i_clr_underflow = 1'b0;
      m_cnt = 0; m_bin = N / 2; m_strobe = 0; m_uf = 0;

      // reset
      repeat (3) step();
      i_rst = 1'b0;
      #1;
      chk("rst_ready", int'(o_ready), 1);
      chk("rst_bin",   int'(o_bin), 32);
      chk("rst_level", int'(o_level), 0);
      chk("rst_strobe", int'(o_strobe), 0);
      chk("rst_uf",    int'(o_underflow), 0);

      // steady rate, div=3: strobes every 4 cycles with 5,10,15
      i_div = 16'd3;
      push_code(5); push_code(10); push_code(15);
      i_en = 1'b1;
      repeat (3) step();
      step(); chk("rate_stb0", int'(o_strobe), 1); chk("rate_bin0", int'(o_bin), 5);
      repeat (3) step();
      step(); chk("rate_stb1", int'(o_strobe), 1); chk("rate_bin1", int'(o_bin), 10);
      repeat (3) step();
      step(); chk("rate_stb2", int'(o_strobe), 1); chk("rate_bin2", int'(o_bin), 15);

      // underflow on the fourth tick, then clear
      repeat (3) step();
      step();
      chk("uf_set", int'(o_underflow), 1);
      chk("uf_bin", int'(o_bin), 15);
      chk("uf_stb", int'(o_strobe), 0);
      i_en = 1'b0;
      clear_uf();
      chk("uf_clr", int'(o_underflow), 0);

      // full: four pushes while disabled, fifth refused even while popping
      push_code(1); push_code(2); push_code(3); push_code(4);
      chk("full_ready", int'(o_ready), 0);
      chk("full_level", int'(o_level), 4);
      i_div = '0; i_en = 1'b1; i_valid = 1'b1; i_data = CW'(63);
      step();
      i_valid = 1'b0;
      chk("full_nopush", int'(o_level), 3);
      chk("full_bin", int'(o_bin), 1);

      // div=0: strobe every cycle while draining
      for (int k = 2; k <= 4; k++) begin
         step();
         chk("div0_stb", int'(o_strobe), 1);
         chk("div0_bin", int'(o_bin), k);
      end
      i_en = 1'b0;
      clear_uf();

      // lowering the divider mid-period ends it on the next cycle
      push_code(7); push_code(9);
      i_div = 16'd100; i_en = 1'b1;
      repeat (50) step();
      i_div = 16'd2;
      step();
      chk("div_drop_stb", int'(o_strobe), 1);
      chk("div_drop_bin", int'(o_bin), 7);
      i_en = 1'b0;
      step();

      // reset mid-run with 3 entries buffered
      push_code(11); push_code(12);
      chk("pre_rst_level", int'(o_level), 3);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      chk("mid_rst_level", int'(o_level), 0);
      chk("mid_rst_bin", int'(o_bin), 32);
      i_en = 1'b1; i_div = 16'd1;
      repeat (6) begin
         step();
         chk("mid_rst_nostb", int'(o_strobe), 0);
      end
      i_en = 1'b0;
      clear_uf();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         i_rst           = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) i_en = ~i_en;
         if ($urandom_range(0, 29) == 0) i_div = DIV_W'($urandom_range(0, 5));
         i_valid         = $urandom_range(0, 1) == 1;
         i_data          = CW'($urandom);
         i_clr_underflow = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/x_dac_sample_sched.md
# x_dac_sample_sched

Sample scheduler for the thermometer DAC path. It accepts binary DAC codes from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. It releases exactly one code per programmable sample period to `x_bin_to_therm`, and flags underflow when no code is ready at a release instant. It owns the sample rate of the DAC so that producers can be bursty.

## Interface
Parameters:
- `N`, 64: thermometer width of the downstream DAC. Code width is `BW = $clog2(N)`.
- `DEPTH`, 4: FIFO entries. Power of two, at least 2.
- `DIV_W`, 16: width of the sample-period divider.

Ports:
- `i_clk`, in, 1: clock. One clock domain only.
- `i_rst`, in, 1: reset. Synchronous and active-high.
- `i_en`, in, 1: scheduler enable.
- `i_div`, in, `DIV_W`: sample period minus one, in clocks.
- `i_valid`, in, 1: upstream code valid.
- `i_data`, in, `BW`: upstream code.
- `o_ready`, out, 1: FIFO can accept a code.
- `o_bin`, out, `BW`: code currently presented to `x_bin_to_therm`.
- `o_strobe`, out, 1: one-cycle pulse. High in the first cycle that a new `o_bin` is visible.
- `o_underflow`, out, 1: sticky flag. Set when a release instant finds the FIFO empty.
- `i_clr_underflow`, in, 1: clears `o_underflow`.
- `o_level`, out, `$clog2(DEPTH)+1`: current FIFO occupancy.

## Operation
- **Push.** A push occurs when `i_valid && o_ready`. `o_ready = !full && !i_rst`, taken from registered state only.
  - A push into a full FIFO is never accepted, even if a pop happens in the same cycle.
- **Period counter.** `cnt` is `DIV_W` bits wide.
  - While `i_en` is 0, `cnt` is held at 0 and no ticks occur.
  - While `i_en` is 1, `tick = (cnt >= i_div)`. On tick, `cnt` goes to 0; otherwise `cnt` increments.
  - Using `>=` means that lowering `i_div` mid-period ends the current period on the next cycle. It never wraps through `2^DIV_W`.
  - `i_div = 0` gives a tick every enabled cycle.
- **On tick with FIFO not empty:** pop the head into `o_bin` and pulse `o_strobe` on the next cycle.
- **On tick with FIFO empty:**
  - `o_bin` holds its value.
  - `o_strobe` stays 0.
  - `o_underflow` is set.
- **Push and pop in the same cycle** (FIFO neither empty nor full): `o_level` is unchanged and ordering is preserved.
- **No bypass.** A push into an empty FIFO in the same cycle as a tick still counts as underflow. The pushed code waits for the next tick.
- **Underflow clear.** If `i_clr_underflow` and an underflow set coincide in the same cycle, the set wins.
- **Disable.** Deasserting `i_en` leaves `o_bin` and the FIFO contents untouched. The producer can prefill the FIFO while disabled.
- **Codes are unsigned.** No saturation is needed: every `BW`-bit value is a legal code.

## Timing
- **Reset values** (on the `i_clk` edge while `i_rst` is high):
  - `o_bin = N/2` (midscale)
  - `o_strobe = 0`
  - `o_underflow = 0`
  - `o_level = 0`
  - `o_ready = 0` during reset, then 1 in the first cycle after reset
  - `cnt = 0`, and FIFO pointers are 0
- **Reset mid-operation** discards all buffered codes. Any partial period is abandoned.
- **Push latency:** a code pushed at edge k appears in `o_level` after edge k.
- **Tick to output:** a tick at cycle t gives `o_bin` and `o_strobe` updated after edge t, which is 1 cycle.
- **End to end:** `x_bin_to_therm` adds 2 cycles, so the thermometer output changes 3 cycles after the tick.
- **Rate:** with `i_en` held high and constant `i_div = D`, ticks occur every `D+1` cycles. The first tick comes `D+1` cycles after `i_en` rises.

## Structure
- **Package `x_dac_pkg`** holds:
  - the localparam function for midscale (`N/2`)
  - the code-width helper `BW(N)`
  - the shared typedef for the code type
- **Sub-module `x_sync_fifo`** (`WIDTH`, `DEPTH`) is reusable elsewhere in the DAC path.
  - Registered array with read/write pointers that are one bit wider than the address, to distinguish full from empty.
  - Provides the `full`, `empty` and `level` outputs.
- **Top level** contains the period counter, the output register and the underflow flag.

## Test plan
1. **Reset:** hold `i_rst` for 3 cycles, then release. Expect `o_bin=32`, `o_ready=1`, `o_level=0`, `o_strobe=0`, `o_underflow=0` (N=64).
2. **Steady rate:** `i_div=3`, prefill codes 5, 10, 15, then set `i_en=1`. Expect strobes 4 cycles apart with `o_bin` = 5, 10, 15, in order.
3. **Underflow:** continue case 2 with no new pushes. At the fourth tick expect `o_underflow=1` and `o_bin` held at 15. Pulse `i_clr_underflow` and expect the flag cleared.
4. **Full:** push 4 codes while disabled. Expect `o_ready=0` and `o_level=4`. A fifth `i_valid` is not accepted, even on a cycle that pops.
5. **Divider edge cases:**
   - With `i_div=0`, expect a strobe every cycle while the FIFO drains.
   - Change `i_div` from 100 to 2 when `cnt=50`. Expect a tick on the next cycle.
6. **Reset mid-run:** assert `i_rst` with 3 entries buffered. Expect `o_level=0` and `o_bin=32`, and no strobe after release until a new push and tick.
